// File: rtl/mc_control_fsm.sv
// Multicycle CPU main controller: sequences datapath enables/selects per instruction and counts retirements.
// Optional macro MC_JAL_EN adds jal (opcode 000011) through the JALWB state.
module mc_control_fsm #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned ILLEGAL_STOP = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             pc_load,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_JAL_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
`ifdef MC_JAL_EN
    S_JALWB  = 4'd13,
`endif
    S_HALT   = 4'd12
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       instr_done;
  } ctl_t;

  state_t           r_state, w_next;
  ctl_t             r_ctl, w_ctl;
  logic             r_run, r_is_lw, r_bne;
  logic             w_unknown;
  logic [CNT_W-1:0] r_retired;
  logic             w_unused_funct;

  // funct is consumed by the ALU decoder, not by this controller
  assign w_unused_funct = ^funct;

  // Next-state logic; r_run holds FETCH until the first edge after reset release
  always_comb begin
    w_next    = r_state;
    w_unknown = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_R:           w_next = S_RTEX;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:           w_next = S_JUMP;
`ifdef MC_JAL_EN
          OP_JAL:         w_next = S_JALWB;
`endif
          default: begin
            w_unknown = 1'b1;
            w_next    = (ILLEGAL_STOP != 0) ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: w_next = r_is_lw ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_RTEX:   w_next = S_RTWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
    if (!r_run) w_next = S_FETCH;
  end

  // Moore outputs of the state being entered, loaded alongside the state register
  always_comb begin
    w_ctl = '0;
    case (w_next)
      S_FETCH: begin
        w_ctl.mem_read  = 1'b1;
        w_ctl.ir_write  = 1'b1;
        w_ctl.alu_src_b = 2'b01;
        w_ctl.pc_write  = 1'b1;
      end
      S_DECODE: w_ctl.alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        w_ctl.mem_read = 1'b1;
        w_ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.mem_to_reg = 2'b01;
        w_ctl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        w_ctl.mem_write  = 1'b1;
        w_ctl.iord       = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_RTEX: begin
        w_ctl.alu_src_a = 1'b1;
        w_ctl.alu_op    = 2'b10;
      end
      S_RTWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = 2'b01;
        w_ctl.instr_done = 1'b1;
      end
      S_ADDIWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        w_ctl.alu_src_a  = 1'b1;
        w_ctl.alu_op     = 2'b01;
        w_ctl.pc_src     = 2'b01;
        w_ctl.branch     = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
      S_JUMP: begin
        w_ctl.pc_src     = 2'b10;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
`ifdef MC_JAL_EN
      S_JALWB: begin
        w_ctl.reg_write  = 1'b1;
        w_ctl.reg_dst    = 2'b10;
        w_ctl.mem_to_reg = 2'b10;
        w_ctl.pc_src     = 2'b10;
        w_ctl.pc_write   = 1'b1;
        w_ctl.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_run     <= 1'b0;
      r_ctl     <= '0;
      r_is_lw   <= 1'b0;
      r_bne     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      r_ctl   <= w_ctl;
      // opcode is only trusted while DECODE holds a fresh IR
      if (r_state == S_DECODE) begin
        r_is_lw <= (opcode == OP_LW);
        r_bne   <= (opcode == OP_BNE);
      end
      if (r_ctl.instr_done) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign IorD       = r_ctl.iord;
  assign MemRead    = r_ctl.mem_read;
  assign MemWrite   = r_ctl.mem_write;
  assign IRWrite    = r_ctl.ir_write;
  assign RegDst     = r_ctl.reg_dst;
  assign MemtoReg   = r_ctl.mem_to_reg;
  assign RegWrite   = r_ctl.reg_write;
  assign ALUSrcA    = r_ctl.alu_src_a;
  assign ALUSrcB    = r_ctl.alu_src_b;
  assign ALUOp      = r_ctl.alu_op;
  assign PCSrc      = r_ctl.pc_src;
  assign instr_done = r_ctl.instr_done;
  assign pc_load    = r_ctl.pc_write | (r_ctl.branch & (r_bne ? ~zero : zero));
  assign illegal    = w_unknown;
  assign retired    = r_retired;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors queued by stimulus, checked by a monitor.
module tb_mc_control_fsm;

  typedef logic [54:0] vec_t;
  typedef struct {
    vec_t  v;
    string nm;
  } item_t;

  localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MWR = 5, S_RT = 6;
  localparam int S_RTW = 7, S_AE = 8, S_AW = 9, S_BR = 10, S_J = 11, S_H = 12, S_JW = 13;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;

  logic        clk, rst, zero;
  logic [5:0]  opcode, funct, op_halt;
  logic        IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, pc_load, instr_done, illegal;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, ALUOp, PCSrc;
  logic [31:0] retired;
  logic [3:0]  state;
  logic        h_iord, h_mr, h_mw, h_irw, h_rw, h_asa, h_pcl, h_done, h_ill;
  logic [1:0]  h_rd, h_m2r, h_asb, h_aop, h_pcs;
  logic [31:0] h_ret;
  logic [3:0]  h_state;

  vec_t act, h_act;
  item_t q[$];
  int vectors = 0;
  int errors  = 0;
  logic [31:0] exp_ret = 0;

  mc_control_fsm #(.CNT_W(32), .ILLEGAL_STOP(0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .pc_load(pc_load),
    .instr_done(instr_done), .illegal(illegal), .retired(retired), .state(state)
  );

  mc_control_fsm #(.CNT_W(32), .ILLEGAL_STOP(1)) u_halt (
    .clk(clk), .rst(rst), .opcode(op_halt), .funct(6'd0), .zero(1'b0),
    .IorD(h_iord), .MemRead(h_mr), .MemWrite(h_mw), .IRWrite(h_irw),
    .RegDst(h_rd), .MemtoReg(h_m2r), .RegWrite(h_rw), .ALUSrcA(h_asa),
    .ALUSrcB(h_asb), .ALUOp(h_aop), .PCSrc(h_pcs), .pc_load(h_pcl),
    .instr_done(h_done), .illegal(h_ill), .retired(h_ret), .state(h_state)
  );

  assign act = {state, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, pc_load, instr_done, illegal, retired};
  assign h_act = {h_state, h_iord, h_mr, h_mw, h_irw, h_rd, h_m2r, h_rw, h_asa,
                  h_asb, h_aop, h_pcs, h_pcl, h_done, h_ill, h_ret};

  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Expected controls for one state, straight from the state/output table
  function automatic vec_t ev(input int st, input logic pcl, input logic ill, input logic [31:0] ret);
    logic iord, mr, mw, irw, rw, asa, pl, done;
    logic [1:0] rd, m2r, asb, aop, pcs;
    {iord, mr, mw, irw, rw, asa, pl, done} = '0;
    {rd, m2r, asb, aop, pcs} = '0;
    case (st)
      S_F:   begin mr = 1; irw = 1; asb = 2'b01; pl = 1; end
      S_D:   asb = 2'b11;
      S_MA:  begin asa = 1; asb = 2'b10; end
      S_MR:  begin mr = 1; iord = 1; end
      S_MWB: begin rw = 1; m2r = 2'b01; done = 1; end
      S_MWR: begin mw = 1; iord = 1; done = 1; end
      S_RT:  begin asa = 1; aop = 2'b10; end
      S_RTW: begin rw = 1; rd = 2'b01; done = 1; end
      S_AE:  begin asa = 1; asb = 2'b10; end
      S_AW:  begin rw = 1; done = 1; end
      S_BR:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pl = pcl; done = 1; end
      S_J:   begin pcs = 2'b10; pl = 1; done = 1; end
      S_JW:  begin rw = 1; rd = 2'b10; m2r = 2'b10; pcs = 2'b10; pl = 1; done = 1; end
      default: ;
    endcase
    return {4'(st), iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, pl, done, ill, ret};
  endfunction

  task automatic chk(input vec_t e, input string nm);
    vectors++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  // Queue the expected cycle sequence, then drive the instruction; stop_at>0 truncates it
  task automatic instr(input logic [5:0] op, input logic z, input string nm, input int stop_at);
    int seq[$];
    item_t it;
    logic ill;
    logic pl;
    int n;
    seq.push_back(S_F);
    seq.push_back(S_D);
    ill = 1'b0;
    case (op)
      OP_LW:          begin seq.push_back(S_MA); seq.push_back(S_MR); seq.push_back(S_MWB); end
      OP_SW:          begin seq.push_back(S_MA); seq.push_back(S_MWR); end
      OP_R:           begin seq.push_back(S_RT); seq.push_back(S_RTW); end
      OP_ADDI:        begin seq.push_back(S_AE); seq.push_back(S_AW); end
      OP_BEQ, OP_BNE: seq.push_back(S_BR);
      OP_J:           seq.push_back(S_J);
`ifdef MC_JAL_EN
      OP_JAL:         seq.push_back(S_JW);
`endif
      default:        ill = 1'b1;
    endcase
    n = (stop_at > 0) ? stop_at : seq.size();
    for (int i = 0; i < n; i++) begin
      pl = (op == OP_BEQ) ? z : ~z;
      it.v  = ev(seq[i], pl, ill && (seq[i] == S_D), exp_ret);
      it.nm = $sformatf("%s_c%0d", nm, i + 1);
      q.push_back(it);
      if (it.v[33]) exp_ret++;
    end
    opcode = op;
    funct  = 6'($urandom);
    zero   = z;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      // after DECODE the opcode bus must be ignored; lw<->sw swap exposes live use
      if (i == 1) opcode = op ^ 6'b001000;
    end
  endtask

  // Monitor: one expected vector per cycle, compared mid-cycle
  always @(negedge clk) begin : mon
    item_t it;
    if (q.size() > 0) begin
      it = q.pop_front();
      vectors++;
      if (act !== it.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", it.nm, act, it.v);
      end
    end
  end

  // ILLEGAL_STOP=1 instance fed a bad opcode: FETCH, DECODE with illegal, then HALT forever
  initial begin : halt_chk
    vec_t e;
    wait (rst === 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      e = (c == 1) ? ev(S_F, 1'b0, 1'b0, 32'd0) :
          (c == 2) ? ev(S_D, 1'b0, 1'b1, 32'd0) : ev(S_H, 1'b0, 1'b0, 32'd0);
      vectors++;
      if (h_act !== e) begin
        errors++;
        $display("FAIL halt_c%0d: got %h expected %h", c, h_act, e);
      end
    end
  end

  initial begin
    rst = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; op_halt = OP_BAD;
    #100 chk('0, "rst_t100");
    #75  chk('0, "rst_t175");
    #25  rst = 1'b1;
    #25  chk('0, "released_before_edge");
    @(posedge clk);
    #1;
    instr(OP_LW,   1'b0, "lw",     0);
    instr(OP_R,    1'b0, "radd",   0);
    instr(OP_SW,   1'b0, "sw",     0);
    instr(OP_BEQ,  1'b1, "beq_z1", 0);
    instr(OP_BEQ,  1'b0, "beq_z0", 0);
    instr(OP_BNE,  1'b0, "bne_z0", 0);
    instr(OP_BNE,  1'b1, "bne_z1", 0);
    instr(OP_ADDI, 1'b1, "addi",   0);
    instr(OP_J,    1'b0, "j",      0);
    instr(OP_BAD,  1'b0, "bad",    0);
    instr(OP_JAL,  1'b0, "jal",    0);
    instr(OP_LW,   1'b0, "lw2",    0);
    // abort an lw while in MEMRD
    instr(OP_LW,   1'b0, "lw_abort", 3);
    #20 rst = 1'b0;
    exp_ret = 32'd0;
    #1   chk('0, "rst_async_memrd");
    #100 chk('0, "rst_hold");
    rst = 1'b1;
    @(posedge clk);
    #1;
    instr(OP_J,    1'b0, "j_after_rst", 0);
    instr(OP_ADDI, 1'b0, "addi_after_rst", 0);
    @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle main controller for the CPU datapath: sequences PC, instruction register, memory, ALU and register file over 3–5 clock cycles per instruction.
- Sits beside the datapath inside cpu. Decodes the registered opcode/funct and drives every datapath enable and mux select, including the register file's RegWrite.
- Also keeps a retired-instruction counter for bench and debug use.

Parameters:
CNT_W, 32, width of retired-instruction counter
ILLEGAL_STOP, 0, 1 = halt in HALT state on unknown opcode; 0 = flag it and resume FETCH

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read enable
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
RegDst  output  2  write-register select: 00 = rt, 01 = rd, 10 = $31
MemtoReg  output  2  write-data select: 00 = ALUOut, 01 = MDR, 10 = PC
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0 = PC, 1 = regA
ALUSrcB  output  2  ALU B select: 00 = regB, 01 = 4, 10 = sext imm, 11 = sext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = funct decode
PCSrc  output  2  PC next select: 00 = ALU result, 01 = ALUOut, 10 = jump target
pc_load  output  1  PC register load
instr_done  output  1  one-cycle pulse in the final state of each instruction
illegal  output  1  one-cycle pulse in DECODE on an unknown opcode
retired  output  CNT_W  count of completed instructions
state  output  4  current state encoding

Behaviour:
- Reset: while rst = 0, state = FETCH, retired = 0, and every output is forced to 0 regardless of state. Reset is asynchronous, so assertion mid-instruction aborts it immediately and no write enable stays high.
- First FETCH cycle is the first rising edge after rst deasserts.
- Output style: all outputs are Moore (decoded from the state register) except pc_load, which is PCWrite | (branch state & condition).
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, addi 001000, j 000010.

States and outputs (unlisted signals are 0):
- FETCH: MemRead, IRWrite, ALUSrcB = 01, ALUOp = 00, PCSrc = 00, pc_load = 1. Next: DECODE.
- DECODE: ALUSrcB = 11, ALUOp = 00.
  - Next by opcode: lw/sw -> MEMADR; R -> RTEX; addi -> ADDIEX; beq/bne -> BRANCH; j -> JUMP.
  - Unknown opcode: illegal pulse, then FETCH (or HALT if ILLEGAL_STOP = 1).
- MEMADR: ALUSrcA = 1, ALUSrcB = 10. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead, IorD = 1. Next: MEMWB.
- MEMWB: RegWrite, RegDst = 00, MemtoReg = 01, instr_done. Next: FETCH.
- MEMWR: MemWrite, IorD = 1, instr_done. Next: FETCH.
- RTEX: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next: RTWB.
- RTWB: RegWrite, RegDst = 01, MemtoReg = 00, instr_done. Next: FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next: ADDIWB.
- ADDIWB: RegWrite, RegDst = 00, instr_done. Next: FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 01.
  - pc_load = zero for beq, ~zero for bne.
  - Asserts instr_done. Next: FETCH.
- JUMP: PCSrc = 10, pc_load = 1, instr_done. Next: FETCH.
- HALT: all outputs 0. Stays in HALT until reset.

Latency and counting:
- Cycles per instruction: lw 5; sw, R and addi 4; beq, bne and j 3.
- retired increments on every cycle where instr_done = 1. It wraps from all-ones to 0 with no flag.
- opcode and funct are sampled only in DECODE and RTEX; changes to them in other states are ignored.

Optional Feature:
MC_JAL_EN
- Defined:
  - Opcode 000011 (jal) in DECODE goes to JALWB.
  - JALWB: RegWrite, RegDst = 10, MemtoReg = 10, PCSrc = 10, pc_load = 1, instr_done. Next: FETCH. jal takes 3 cycles.
- Undefined: 000011 is treated as an unknown opcode, and the JALWB state and its encoding do not exist.

Test Plan:
- rst = 0 for 200 ns with clk period 100 ns, then release -> all outputs 0 during reset; FETCH with MemRead = IRWrite = pc_load = 1 on the first edge after release; retired = 0.
- lw (opcode 100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite = 1 only in cycle 5 with MemtoReg = 01 and RegDst = 00; retired = 1.
- R add then sw -> RegWrite in cycle 4 of R with RegDst = 01; MemWrite = 1 in cycle 4 of sw; RegWrite never 1 during sw; retired = 2.
- beq with zero = 1 and then zero = 0; bne with zero = 0 -> pc_load = 1, 0, 1 respectively in the BRANCH cycle; PCSrc = 01 each time.
- Opcode 111111 with ILLEGAL_STOP = 0 -> illegal pulses for 1 cycle in DECODE, then FETCH, retired unchanged. With ILLEGAL_STOP = 1 -> enters HALT and all outputs stay 0.
- rst asserted mid-MEMRD of lw -> outputs 0 immediately (asynchronous), RegWrite never pulses, retired = 0, FETCH on release. With MC_JAL_EN, jal -> JALWB asserts RegWrite, RegDst = 10, pc_load.
